// File: rtl/uart_alici_tampon.sv
// uart_alici_tampon
//   Receive-side byte FIFO that sits directly after the UART receiver. Each
//   alinan_gecerli_i cycle writes one byte. The read side is a show-ahead
//   valid/ready port, so the head word is always visible on veri_o. The block
//   also reports empty, full, occupancy and a sticky overrun flag.
// Ports
//   clk_i, rstn_i     clock (rising edge) and asynchronous active-low reset
//   alinan_veri_i     received byte
//   alinan_gecerli_i  write strobe (one write per high cycle)
//   veri_o            head-of-FIFO word (0 while empty)
//   veri_gecerli_o    veri_o holds valid data
//   veri_hazir_i      consumer ready; pop on valid & ready
//   bos_o / dolu_o    empty / full
//   doluluk_o         word count 0..DERINLIK
//   tasma_o           sticky overrun flag
//   tasma_temizle_i   clears tasma_o
//   bosalt_i          synchronous flush
module uart_alici_tampon #(
  parameter int VERI_BIT  = 8,
  parameter int DERINLIK  = 16,
  parameter int ADRES_BIT = $clog2(DERINLIK)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [VERI_BIT-1:0] alinan_veri_i,
  input  logic                alinan_gecerli_i,
  output logic [VERI_BIT-1:0] veri_o,
  output logic                veri_gecerli_o,
  input  logic                veri_hazir_i,
  output logic                bos_o,
  output logic                dolu_o,
  output logic [ADRES_BIT:0]  doluluk_o,
  output logic                tasma_o,
  input  logic                tasma_temizle_i,
  input  logic                bosalt_i
);

  localparam logic [ADRES_BIT:0] DOLU_SAYI = (ADRES_BIT+1)'(DERINLIK);

  logic [VERI_BIT-1:0]  mem [DERINLIK];
  logic [ADRES_BIT-1:0] yaz_ptr, oku_ptr;
  logic [ADRES_BIT:0]   sayac;
  logic                 push, pop, tasma_olay;

  assign bos_o          = (sayac == '0);
  assign dolu_o         = (sayac == DOLU_SAYI);
  assign doluluk_o      = sayac;
  assign veri_gecerli_o = !bos_o;

  assign pop  = veri_gecerli_o && veri_hazir_i;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted.
  assign push = alinan_gecerli_i && (!dolu_o || pop);
  // The overrun is independent of the flush. A flush in the same cycle still
  // records the lost byte.
  assign tasma_olay = alinan_gecerli_i && dolu_o && !pop;

  // Show-ahead read from the registered pointer. Force zero while empty so
  // stale storage is never exposed.
  assign veri_o = bos_o ? '0 : mem[oku_ptr];

  // Storage has no reset. The flush also blocks the write.
  always_ff @(posedge clk_i) begin
    if (push && !bosalt_i) mem[yaz_ptr] <= alinan_veri_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else if (bosalt_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else begin
      if (push) yaz_ptr <= yaz_ptr + ADRES_BIT'(1);
      if (pop)  oku_ptr <= oku_ptr + ADRES_BIT'(1);
      case ({push, pop})
        2'b10:   sayac <= sayac + (ADRES_BIT+1)'(1);
        2'b01:   sayac <= sayac - (ADRES_BIT+1)'(1);
        default: sayac <= sayac;
      endcase
    end
  end

  // A new overrun wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)              tasma_o <= 1'b0;
    else if (tasma_olay)      tasma_o <= 1'b1;
    else if (tasma_temizle_i) tasma_o <= 1'b0;
  end

endmodule
